// File: rtl/led_pkg.sv
// led_pkg: shared types and helpers for the LED pattern generator.
//   mode_e      - pattern mode encoding as seen on the mode input
//   colour_e    - RGB status colour sequence, advanced once per pattern wrap
//   dir_e       - direction for the SCAN bit and the BREATHE duty ramp
//   start_value - pattern loaded on reset or on a mode change
package led_pkg;

    typedef enum logic [1:0] {
        COUNTDOWN = 2'd0,
        SCAN      = 2'd1,
        COUNTUP   = 2'd2,
        BREATHE   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        WHITE = 2'd0,
        RED   = 2'd1,
        GREEN = 2'd2,
        BLUE  = 2'd3
    } colour_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int unsigned MAX_LEDS = 32;

    // Returned at full width; the caller truncates to its own LED count.
    // BREATHE starts at duty 0, so its pattern start value is all zero.
    function automatic logic [MAX_LEDS-1:0] start_value(input mode_e m,
                                                        input int unsigned n_leds);
        logic [MAX_LEDS-1:0] v;
        v = '0;
        if (m == COUNTDOWN) begin
            v = {MAX_LEDS{1'b1}} >> (MAX_LEDS - n_leds);
        end else if (m == SCAN) begin
            v = 32'd1;
        end
        return v;
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// led_prescaler: free-running prescaler producing the pattern step tick and
// a slow heartbeat.
//   clk0      in   clock
//   rst       in   synchronous, active-low reset
//   speed     in   tick period = 2^(BASE_BITS+speed) cycles
//   freeze    in   suppresses tick; the prescaler itself keeps counting
//   tick      out  registered one-cycle pulse per pattern step
//   heartbeat out  registered copy of prescaler bit BASE_BITS+6
module led_prescaler #(
    parameter int BASE_BITS = 20
) (
    input  logic       clk0,
    input  logic       rst,
    input  logic [2:0] speed,
    input  logic       freeze,
    output logic       tick,
    output logic       heartbeat
);

    localparam int PW = BASE_BITS + 7;

    logic [PW-1:0] presc;
    logic [PW-1:0] mask;
    logic          match;

    // mask covers bits [BASE_BITS+speed-1:0]; speed is read live, so a new
    // speed simply changes which prescaler value matches next.
    always_comb begin
        mask  = {PW{1'b1}} >> (3'd7 - speed);
        match = &(presc | ~mask);
    end

    always_ff @(posedge clk0) begin
        if (!rst) begin
            presc     <= '0;
            tick      <= 1'b0;
            heartbeat <= 1'b0;
        end else begin
            presc     <= presc + PW'(1);
            tick      <= match & ~freeze;
            heartbeat <= presc[BASE_BITS+6];
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: LED pattern generator with four modes (COUNTDOWN, SCAN,
// COUNTUP, BREATHE), an RGB status colour that advances on every pattern
// wrap, and a heartbeat.
//   clk0      in   clock
//   rst       in   synchronous, active-low reset
//   mode      in   0 COUNTDOWN, 1 SCAN, 2 COUNTUP, 3 BREATHE
//   speed     in   tick period = 2^(BASE_BITS+speed) cycles
//   freeze    in   hold pattern, colour and duty while high
//   leds      out  pattern, active-high (PWM of duty in BREATHE)
//   rgb_r/g/b out  status colour, active-low
//   tick      out  one-cycle pulse per pattern step
//   heartbeat out  slow prescaler bit
//
// Handshake: there is no backpressure anywhere. tick acts as a valid strobe
// with ready permanently high: every cycle tick is high (and freeze is low)
// the pattern takes exactly one step, and the pins show it one cycle later.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int N_LEDS    = 8,
    parameter int BASE_BITS = 20,
    parameter int PWM_BITS  = 6
) (
    input  logic              clk0,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [2:0]        speed,
    input  logic              freeze,
    output logic [N_LEDS-1:0] leds,
    output logic              rgb_r,
    output logic              rgb_g,
    output logic              rgb_b,
    output logic              tick,
    output logic              heartbeat
);

    localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};

    mode_e               mode_q, mode_q_nx;
    dir_e                dir, dir_nx;
    colour_e             colour, colour_nx;
    logic [N_LEDS-1:0]   pattern, pattern_nx;
    logic [N_LEDS-1:0]   start_pat;
    logic [PWM_BITS-1:0] duty, duty_nx;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                reload;
    logic                step;
    logic                wrap;

    led_prescaler #(
        .BASE_BITS (BASE_BITS)
    ) u_prescaler (
        .clk0      (clk0),
        .rst       (rst),
        .speed     (speed),
        .freeze    (freeze),
        .tick      (tick),
        .heartbeat (heartbeat)
    );

    assign start_pat = N_LEDS'(start_value(mode_e'(mode), N_LEDS));

    // Next-state logic. A mode change reloads the start value and takes
    // priority over a coincident step, so that cycle can never wrap.
    // Freeze also holds off the reload, keeping all pattern state still.
    always_comb begin
        mode_q_nx  = mode_q;
        dir_nx     = dir;
        colour_nx  = colour;
        pattern_nx = pattern;
        duty_nx    = duty;
        wrap       = 1'b0;
        reload     = (mode_e'(mode) != mode_q) && !freeze;
        step       = tick && !freeze;

        if (reload) begin
            mode_q_nx  = mode_e'(mode);
            pattern_nx = start_pat;
            dir_nx     = DIR_UP;
            duty_nx    = '0;
        end else if (step) begin
            case (mode_q)
                COUNTDOWN: begin
                    pattern_nx = pattern - N_LEDS'(1);
                    wrap       = (pattern == '0);
                end
                COUNTUP: begin
                    pattern_nx = pattern + N_LEDS'(1);
                    wrap       = &pattern;
                end
                SCAN: begin
                    // Turn around on arriving at either end so the one-hot
                    // bit never shifts out of the vector.
                    if (dir == DIR_UP) begin
                        pattern_nx = pattern << 1;
                        if (pattern[N_LEDS-2]) dir_nx = DIR_DOWN;
                    end else begin
                        pattern_nx = pattern >> 1;
                        if (pattern[1]) begin
                            dir_nx = DIR_UP;
                            wrap   = 1'b1;
                        end
                    end
                end
                BREATHE: begin
                    if (dir == DIR_UP) begin
                        duty_nx = duty + PWM_BITS'(1);
                        if (duty == DUTY_MAX - PWM_BITS'(1)) dir_nx = DIR_DOWN;
                    end else begin
                        duty_nx = duty - PWM_BITS'(1);
                        if (duty == PWM_BITS'(1)) begin
                            dir_nx = DIR_UP;
                            wrap   = 1'b1;
                        end
                    end
                end
                default: begin
                    pattern_nx = pattern;
                end
            endcase
        end

        if (wrap) colour_nx = colour_e'(colour + 2'd1);
    end

    always_ff @(posedge clk0) begin
        if (!rst) begin
            mode_q  <= mode_e'(mode);
            dir     <= DIR_UP;
            colour  <= WHITE;
            pattern <= start_pat;
            duty    <= '0;
            pwm_cnt <= '0;
        end else begin
            mode_q  <= mode_q_nx;
            dir     <= dir_nx;
            colour  <= colour_nx;
            pattern <= pattern_nx;
            duty    <= duty_nx;
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Output registers: pins lag internal state by one cycle. Under reset
    // the pins show the start pattern of the requested mode and white.
    always_ff @(posedge clk0) begin
        if (!rst) begin
            leds  <= start_pat;
            rgb_r <= 1'b0;
            rgb_g <= 1'b0;
            rgb_b <= 1'b0;
        end else begin
            if (mode_q == BREATHE) begin
                leds <= {N_LEDS{pwm_cnt < duty}};
            end else begin
                leds <= pattern;
            end
            rgb_r <= !(colour == WHITE || colour == RED);
            rgb_g <= !(colour == WHITE || colour == GREEN);
            rgb_b <= !(colour == WHITE || colour == BLUE);
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen with N_LEDS=8, BASE_BITS=2,
// PWM_BITS=3. Stimulus pushes the expected pins for each upcoming tick into
// exp_q; the monitor pops one entry per observed tick and compares.
// Entry layout: {pwm_flag, leds_or_duty[7:0], rgb[2:0]}.
module tb_led_pattern_gen;

    localparam int W = 12;

    logic       clk0;
    logic       rst;
    logic [1:0] mode;
    logic [2:0] speed;
    logic       freeze;
    logic [7:0] leds;
    logic       rgb_r, rgb_g, rgb_b;
    logic       tick;
    logic       heartbeat;

    logic [W-1:0] exp_q[$];
    int           pending;
    int           n_chk;
    int           n_pass;
    int           cyc;
    bit           mon_en;

    logic [7:0] scan_seq [14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic [7:0] duty_seq [14] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7,
                                  8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};

    led_pattern_gen #(
        .N_LEDS    (8),
        .BASE_BITS (2),
        .PWM_BITS  (3)
    ) dut (
        .clk0      (clk0),
        .rst       (rst),
        .mode      (mode),
        .speed     (speed),
        .freeze    (freeze),
        .leds      (leds),
        .rgb_r     (rgb_r),
        .rgb_g     (rgb_g),
        .rgb_b     (rgb_b),
        .tick      (tick),
        .heartbeat (heartbeat)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk0 = 1'b0;
        forever #5 clk0 = ~clk0;
    end

    // cyc = number of clock edges since reset was released
    always @(posedge clk0) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_chk);
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    endtask

    // active-low colour: WHITE=000, RED=011, GREEN=101, BLUE=110
    function automatic logic [2:0] rgb_of(input int c);
        return {!(c == 0 || c == 1), !(c == 0 || c == 2), !(c == 0 || c == 3)};
    endfunction

    task automatic push_exp(input logic pwm, input logic [7:0] v, input int colour);
        exp_q.push_back({pwm, v, rgb_of(colour)});
        pending++;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while (pending != 0 && n < max_cycles) begin
            @(negedge clk0);
            #1;
            n++;
        end
        if (pending != 0) begin
            check("drain_timeout", 32'(pending), 32'd0);
            exp_q.delete();
            pending = 0;
        end
    endtask

    task automatic do_reset(input logic [1:0] m, input logic [2:0] s, input logic [7:0] exp_leds);
        mon_en = 1'b0;
        rst    = 1'b0;
        mode   = m;
        speed  = s;
        freeze = 1'b0;
        repeat (3) @(negedge clk0);
        check("reset_leds", 32'(leds), 32'(exp_leds));
        check("reset_rgb", 32'({rgb_r, rgb_g, rgb_b}), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_heartbeat", 32'(heartbeat), 32'd0);
        rst    = 1'b1;
        mon_en = 1'b1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        int           last_tick;
        int           on_cnt;
        int           off_cnt;
        logic [W-1:0] e;
        last_tick = -1;
        forever begin
            @(negedge clk0);
            if (!rst || !mon_en || freeze) begin
                last_tick = -1;
            end else if (tick) begin
                if (last_tick >= 0) check("tick_period", 32'(cyc - last_tick), 32'(1 << (2 + speed)));
                last_tick = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_tick", 32'(tick), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    // step lands on the next edge, pins one edge after that
                    @(posedge clk0);
                    @(posedge clk0);
                    if (e[11]) begin
                        on_cnt  = 0;
                        off_cnt = 0;
                        for (int i = 0; i < 8; i++) begin
                            @(negedge clk0);
                            if (i == 0) check("rgb", 32'({rgb_r, rgb_g, rgb_b}), 32'(e[2:0]));
                            if (leds == 8'hFF) on_cnt++;
                            else if (leds == 8'h00) off_cnt++;
                        end
                        check("pwm_on", 32'(on_cnt), 32'(e[10:3]));
                        check("pwm_total", 32'(on_cnt + off_cnt), 32'd8);
                    end else begin
                        @(negedge clk0);
                        check("leds", 32'(leds), 32'(e[10:3]));
                        check("rgb", 32'({rgb_r, rgb_g, rgb_b}), 32'(e[2:0]));
                    end
                    pending--;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        bit         found;
        int         toggles;
        logic       prev_hb;
        n_chk   = 0;
        n_pass  = 0;
        pending = 0;
        mon_en  = 1'b0;
        rst     = 1'b0;
        mode    = 2'd0;
        speed   = 3'd0;
        freeze  = 1'b0;

        // COUNTDOWN: 256 ticks wrap back to FF with colour RED, then run
        // down to 00 so the next tick would wrap again.
        do_reset(2'd0, 3'd0, 8'hFF);
        for (int k = 1; k <= 511; k++) push_exp(1'b0, 8'(255 - k), (k < 256) ? 0 : 1);
        wait_drain(511 * 4 + 40);

        // Switch to COUNTUP exactly while tick is high: reload must win,
        // no wrap, colour stays RED.
        mon_en = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            @(negedge clk0);
            if (tick) begin
                mode  = 2'd2;
                found = 1'b1;
            end
        end
        check("switch_tick_seen", 32'(found), 32'd1);
        if (found) begin
            @(posedge clk0);
            @(posedge clk0);
            @(negedge clk0);
            check("switch_leds", 32'(leds), 32'h00);
            check("switch_rgb", 32'({rgb_r, rgb_g, rgb_b}), 32'(rgb_of(1)));
        end
        mon_en = 1'b1;
        push_exp(1'b0, 8'h01, 1);
        push_exp(1'b0, 8'h02, 1);
        wait_drain(2 * 4 + 40);

        // SCAN: full bounce, colour steps once on the return to bit 0,
        // then climb to 0x20 and reset for a single cycle.
        do_reset(2'd1, 3'd0, 8'h01);
        for (int i = 0; i < 14; i++) push_exp(1'b0, scan_seq[i], (i == 13) ? 1 : 0);
        for (int i = 0; i < 5; i++) push_exp(1'b0, scan_seq[i], 1);
        wait_drain(19 * 4 + 40);
        mon_en = 1'b0;
        rst    = 1'b0;
        @(posedge clk0);
        @(negedge clk0);
        check("midscan_reset_leds", 32'(leds), 32'h01);
        check("midscan_reset_rgb", 32'({rgb_r, rgb_g, rgb_b}), 32'd0);
        rst    = 1'b1;
        mon_en = 1'b1;
        push_exp(1'b0, 8'h02, 0);
        push_exp(1'b0, 8'h04, 0);
        wait_drain(2 * 4 + 40);

        // BREATHE at speed 2 (16-cycle steps): duty 1..7..0, each step
        // observed over 8 PWM cycles; wrap at duty 0.
        do_reset(2'd3, 3'd2, 8'h00);
        for (int i = 0; i < 14; i++) push_exp(1'b1, duty_seq[i], (i == 13) ? 1 : 0);
        wait_drain(14 * 16 + 60);

        // Freeze: COUNTUP to 0x38, then hold 50 cycles spanning the first
        // heartbeat rise (cycle 257), then resume.
        do_reset(2'd2, 3'd0, 8'h00);
        for (int i = 1; i <= 56; i++) push_exp(1'b0, 8'(i), 0);
        wait_drain(56 * 4 + 40);
        freeze  = 1'b1;
        toggles = 0;
        prev_hb = heartbeat;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk0);
            check("freeze_leds", 32'(leds), 32'h38);
            check("freeze_tick", 32'(tick), 32'd0);
            check("freeze_heartbeat", 32'(heartbeat), 32'(((cyc - 1) >> 8) & 1));
            if (heartbeat != prev_hb) toggles++;
            prev_hb = heartbeat;
        end
        check("freeze_hb_toggled", 32'(toggles > 0), 32'd1);
        freeze = 1'b0;
        push_exp(1'b0, 8'h39, 0);
        push_exp(1'b0, 8'h3A, 0);
        wait_drain(2 * 4 + 40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
